register_writeback_arbiter: RTL and testbench

- Shares the single write port of the 32x32 register bank between two writeback requesters: the ALU and the memory/load unit.
- Keeps a pending-write scoreboard so decode can detect read-after-write hazards on the two source operands.
- Sits between the execute/memory stages and the register bank. It drives the bank's write_enabled, register_destiny and write_data inputs from a registered output stage.
- Also counts arbitration-conflict cycles for performance monitoring.

---
 rtl/register_writeback_arbiter.sv | 144 ++++++++++++++
 tb/tb_register_writeback_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_writeback_arbiter.sv
// Round-robin arbiter sharing the register bank write port between ALU and load writebacks,
// with a pending-write scoreboard for decode hazard detection and a conflict-cycle counter.
module register_writeback_arbiter #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 5,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,

    input  logic                   alu_valid,
    input  logic [ADDR_WIDTH-1:0]  alu_destiny,
    input  logic [DATA_WIDTH-1:0]  alu_data,
    output logic                   alu_ready,

    input  logic                   mem_valid,
    input  logic [ADDR_WIDTH-1:0]  mem_destiny,
    input  logic [DATA_WIDTH-1:0]  mem_data,
    output logic                   mem_ready,

    input  logic                   issue_valid,
    input  logic [ADDR_WIDTH-1:0]  issue_destiny,
    input  logic [ADDR_WIDTH-1:0]  register_source1,
    input  logic [ADDR_WIDTH-1:0]  register_source2,
    output logic                   hazard1,
    output logic                   hazard2,

    output logic                   write_enabled,
    output logic [ADDR_WIDTH-1:0]  register_destiny,
    output logic [DATA_WIDTH-1:0]  write_data,

    output logic [COUNT_WIDTH-1:0] conflict_count
);

    localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;

    typedef enum logic {
        PrioAlu,
        PrioMem
    } prio_e;

    prio_e                  prio_q, prio_d;
    logic                   write_enabled_q, write_enabled_d;
    logic [ADDR_WIDTH-1:0]  register_destiny_q, register_destiny_d;
    logic [DATA_WIDTH-1:0]  write_data_q, write_data_d;
    logic [NumRegs-1:0]     pending_q, pending_d;
    logic [COUNT_WIDTH-1:0] conflict_count_q, conflict_count_d;

    logic                   alu_accept;
    logic                   mem_accept;
    logic                   accept;
    logic [ADDR_WIDTH-1:0]  grant_destiny;
    logic [DATA_WIDTH-1:0]  grant_data;

    // Readies depend only on the valids and the pointer; both held low during reset.
    always_comb begin
        alu_ready = 1'b0;
        mem_ready = 1'b0;
        if (reset_n) begin
            if (alu_valid && (!mem_valid || prio_q == PrioAlu)) begin
                alu_ready = 1'b1;
            end else if (mem_valid) begin
                mem_ready = 1'b1;
            end
        end
    end

    assign alu_accept    = alu_valid && alu_ready;
    assign mem_accept    = mem_valid && mem_ready;
    assign accept        = alu_accept || mem_accept;
    assign grant_destiny = alu_accept ? alu_destiny : mem_destiny;
    assign grant_data    = alu_accept ? alu_data : mem_data;

    always_comb begin
        prio_d = prio_q;
        if (alu_accept) begin
            prio_d = PrioMem;
        end else if (mem_accept) begin
            prio_d = PrioAlu;
        end
    end

    always_comb begin
        write_enabled_d    = 1'b0;
        register_destiny_d = register_destiny_q;
        write_data_d       = write_data_q;
        if (accept) begin
            write_enabled_d    = (grant_destiny != '0);
            register_destiny_d = grant_destiny;
            write_data_d       = grant_data;
        end
    end

    // Clear before set so a same-edge issue keeps the newer producer outstanding.
    always_comb begin
        pending_d = pending_q;
        if (accept) begin
            pending_d[grant_destiny] = 1'b0;
        end
        if (issue_valid && issue_destiny != '0) begin
            pending_d[issue_destiny] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_comb begin
        conflict_count_d = conflict_count_q;
        if (alu_valid && mem_valid && conflict_count_q != '1) begin
            conflict_count_d = conflict_count_q + COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prio_q             <= PrioAlu;
            write_enabled_q    <= 1'b0;
            register_destiny_q <= '0;
            write_data_q       <= '0;
            pending_q          <= '0;
            conflict_count_q   <= '0;
        end else begin
            prio_q             <= prio_d;
            write_enabled_q    <= write_enabled_d;
            register_destiny_q <= register_destiny_d;
            write_data_q       <= write_data_d;
            pending_q          <= pending_d;
            conflict_count_q   <= conflict_count_d;
        end
    end

    // The write-stage term covers the cycle between scoreboard clear and bank update.
    assign hazard1 = (register_source1 != '0) &&
                     (pending_q[register_source1] ||
                      (write_enabled_q && register_destiny_q == register_source1));
    assign hazard2 = (register_source2 != '0) &&
                     (pending_q[register_source2] ||
                      (write_enabled_q && register_destiny_q == register_source2));

    assign write_enabled    = write_enabled_q;
    assign register_destiny = register_destiny_q;
    assign write_data       = write_data_q;
    assign conflict_count   = conflict_count_q;

endmodule

// File: tb/tb_register_writeback_arbiter.sv
// Directed and randomized bench for register_writeback_arbiter, checked against a
// cycle-level reference model of the arbitration, scoreboard and counter rules.
module tb_register_writeback_arbiter;

    logic        clock;
    logic        reset_n;
    logic        alu_valid;
    logic [4:0]  alu_destiny;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [4:0]  mem_destiny;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        issue_valid;
    logic [4:0]  issue_destiny;
    logic [4:0]  register_source1;
    logic [4:0]  register_source2;
    logic        hazard1;
    logic        hazard2;
    logic        write_enabled;
    logic [4:0]  register_destiny;
    logic [31:0] write_data;
    logic [15:0] conflict_count;

    register_writeback_arbiter #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (5),
        .COUNT_WIDTH(16)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .alu_valid       (alu_valid),
        .alu_destiny     (alu_destiny),
        .alu_data        (alu_data),
        .alu_ready       (alu_ready),
        .mem_valid       (mem_valid),
        .mem_destiny     (mem_destiny),
        .mem_data        (mem_data),
        .mem_ready       (mem_ready),
        .issue_valid     (issue_valid),
        .issue_destiny   (issue_destiny),
        .register_source1(register_source1),
        .register_source2(register_source2),
        .hazard1         (hazard1),
        .hazard2         (hazard2),
        .write_enabled   (write_enabled),
        .register_destiny(register_destiny),
        .write_data      (write_data),
        .conflict_count  (conflict_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model state: registers awaiting writeback, last write presented to the bank,
    // which side won the most recent grant, and the conflict cycle count.
    bit          exp_pend [32];
    bit          exp_we;
    logic [4:0]  exp_dest;
    logic [31:0] exp_data;
    bit          last_mem;
    int          exp_count;

    // Values observed just before the most recent edge, for directed checks.
    bit obs_alu_ready, obs_mem_ready, obs_h1;
    bit g_alu, g_mem;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) exp_pend[r] = 1'b0;
        exp_we    = 1'b0;
        exp_dest  = '0;
        exp_data  = '0;
        last_mem  = 1'b1;
        exp_count = 0;
    endtask

    task automatic idle();
        alu_valid   = 1'b0;
        mem_valid   = 1'b0;
        issue_valid = 1'b0;
    endtask

    // One clock cycle: check combinational outputs, cross the edge, advance the model,
    // then check the registered outputs.
    task automatic step();
        bit ga, gm, h1, h2;
        #1;
        ga = alu_valid && (!mem_valid || last_mem);
        gm = mem_valid && !ga;
        h1 = (register_source1 != 0) &&
             (exp_pend[register_source1] || (exp_we && exp_dest == register_source1));
        h2 = (register_source2 != 0) &&
             (exp_pend[register_source2] || (exp_we && exp_dest == register_source2));
        obs_alu_ready = alu_ready;
        obs_mem_ready = mem_ready;
        obs_h1        = hazard1;
        check("alu_ready", alu_ready, ga);
        check("mem_ready", mem_ready, gm);
        check("hazard1", hazard1, h1);
        check("hazard2", hazard2, h2);
        @(posedge clock);
        if (alu_valid && mem_valid && exp_count < 65535) exp_count++;
        if (ga || gm) begin
            exp_dest = ga ? alu_destiny : mem_destiny;
            exp_data = ga ? alu_data : mem_data;
            exp_we   = (exp_dest != 0);
            exp_pend[exp_dest] = 1'b0;
            last_mem = gm;
        end else begin
            exp_we = 1'b0;
        end
        if (issue_valid && issue_destiny != 0) exp_pend[issue_destiny] = 1'b1;
        g_alu = ga;
        g_mem = gm;
        #1;
        check("write_enabled", write_enabled, exp_we);
        check("register_destiny", register_destiny, exp_dest);
        check("write_data", write_data, exp_data);
        check("conflict_count", conflict_count, exp_count);
    endtask

    initial begin
        bit         alu_hold, mem_hold;
        logic [4:0] d;

        reset_n          = 1'b0;
        alu_destiny      = '0;
        alu_data         = '0;
        mem_destiny      = '0;
        mem_data         = '0;
        issue_destiny    = '0;
        register_source1 = '0;
        register_source2 = '0;
        alu_hold         = 1'b0;
        mem_hold         = 1'b0;
        idle();
        model_reset();
        repeat (2) @(negedge clock);
        check("reset_write_enabled", write_enabled, 1'b0);
        check("reset_register_destiny", register_destiny, 5'd0);
        check("reset_write_data", write_data, 32'd0);
        check("reset_conflict_count", conflict_count, 16'd0);
        reset_n = 1'b1;

        // Reset while a write is presented to the bank.
        issue_valid = 1'b1; issue_destiny = 5'd9;
        step();
        issue_valid = 1'b0;
        alu_valid = 1'b1; alu_destiny = 5'd3; alu_data = 32'hAABBCCDD;
        mem_valid = 1'b1; mem_destiny = 5'd4; mem_data = 32'h11223344;
        register_source1 = 5'd9;
        step();
        check("pre_reset_write_enabled", write_enabled, 1'b1);
        reset_n = 1'b0;
        #1;
        check("async_reset_write_enabled", write_enabled, 1'b0);
        check("async_reset_register_destiny", register_destiny, 5'd0);
        check("async_reset_write_data", write_data, 32'd0);
        check("async_reset_conflict_count", conflict_count, 16'd0);
        check("async_reset_alu_ready", alu_ready, 1'b0);
        check("async_reset_mem_ready", mem_ready, 1'b0);
        check("async_reset_hazard1", hazard1, 1'b0);
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;

        // Contention: fresh requests on both sides each cycle.
        for (int i = 0; i < 4; i++) begin
            alu_valid = 1'b1; alu_destiny = 5'(i + 1);  alu_data = $urandom;
            mem_valid = 1'b1; mem_destiny = 5'(i + 10); mem_data = $urandom;
            step();
            check("contention_alu_grant", obs_alu_ready, (i % 2 == 0));
            check("contention_mem_grant", obs_mem_ready, (i % 2 == 1));
        end
        check("contention_count", conflict_count, 16'd4);
        idle();

        // Single ALU write and hazard lifetime.
        issue_valid = 1'b1; issue_destiny = 5'd5; register_source1 = 5'd5;
        step();
        issue_valid = 1'b0;
        alu_valid = 1'b1; alu_destiny = 5'd5; alu_data = 32'hDEADBEEF;
        step();
        check("single_alu_ready", obs_alu_ready, 1'b1);
        check("single_hazard_pending", obs_h1, 1'b1);
        check("single_write_enabled", write_enabled, 1'b1);
        check("single_register_destiny", register_destiny, 5'd5);
        check("single_write_data", write_data, 32'hDEADBEEF);
        idle();
        step();
        check("single_hazard_write_stage", obs_h1, 1'b1);
        check("single_write_enabled_drop", write_enabled, 1'b0);
        step();
        check("single_hazard_clear", obs_h1, 1'b0);

        // Writeback to r0.
        mem_valid = 1'b1; mem_destiny = 5'd0; mem_data = 32'hCAFEF00D;
        register_source1 = 5'd0; register_source2 = 5'd0;
        step();
        check("r0_mem_ready", obs_mem_ready, 1'b1);
        check("r0_write_enabled", write_enabled, 1'b0);
        check("r0_hazard", hazard1, 1'b0);
        idle();

        // Issue and writeback to the same register at the same edge.
        issue_valid = 1'b1; issue_destiny = 5'd7; register_source1 = 5'd7;
        step();
        alu_valid = 1'b1; alu_destiny = 5'd7; alu_data = 32'h00000777;
        step();
        idle();
        step();
        step();
        check("same_edge_hazard", obs_h1, 1'b1);
        alu_valid = 1'b1;
        step();
        idle();
        step();

        // Randomized traffic with requesters holding until accepted.
        for (int i = 0; i < 400; i++) begin
            if (!alu_hold) begin
                alu_valid   = ($urandom_range(0, 2) != 0);
                alu_destiny = 5'($urandom_range(0, 31));
                alu_data    = $urandom;
            end
            if (!mem_hold) begin
                mem_valid   = ($urandom_range(0, 2) != 0);
                mem_destiny = 5'($urandom_range(0, 31));
                mem_data    = $urandom;
            end
            d = 5'($urandom_range(0, 31));
            if (!exp_pend[d] && $urandom_range(0, 1) == 1) begin
                issue_valid   = 1'b1;
                issue_destiny = d;
            end else begin
                issue_valid = 1'b0;
            end
            register_source1 = 5'($urandom_range(0, 31));
            register_source2 = 5'($urandom_range(0, 31));
            step();
            alu_hold = alu_valid && !g_alu;
            mem_hold = mem_valid && !g_mem;
        end
        idle();

        // Counter saturation.
        reset_n = 1'b0;
        #2;
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        alu_valid = 1'b1; alu_destiny = 5'd0;
        mem_valid = 1'b1; mem_destiny = 5'd0;
        repeat (65534) @(posedge clock);
        #1;
        check("count_before_saturation", conflict_count, 16'hFFFE);
        @(posedge clock);
        #1;
        check("count_saturated", conflict_count, 16'hFFFF);
        repeat (3) @(posedge clock);
        #1;
        check("count_holds", conflict_count, 16'hFFFF);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
